// File: rtl/bridge_arbiter_if.sv
// One master's single-beat request/response channel into the bridge arbiter.
// req/addr/wd/we are held by the master until ack; ack/err/rd come back from the arbiter.
interface bridge_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        ack;
    logic        err;
    logic [31:0] rd;

    modport master (
        output req, addr, wd, we,
        input  ack, err, rd
    );

    modport slave (
        input  req, addr, wd, we,
        output ack, err, rd
    );
endinterface

// File: rtl/bridge_arbiter.sv
// Round-robin two-master arbiter/sequencer for the bridge processor port; legal access acks
// at t+WAIT_CYCLES+2, decode error at t+1; losers simply hold req until granted (no preemption).
module bridge_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7f00,
    parameter logic [31:0] DEV_LAST    = 32'h0000_7f43,
    parameter logic [31:0] HOLE_LO     = 32'h0000_7f0c,
    parameter logic [31:0] HOLE_HI     = 32'h0000_7f0f
) (
    input  logic                    clk,
    input  logic                    reset,
    bridge_arbiter_if.slave         m0,
    bridge_arbiter_if.slave         m1,
    output logic [31:0]             PrAddr,
    output logic [31:0]             PrWD,
    output logic                    PrWE,
    input  logic [31:0]             PrRD,
    output logic                    busy,
    output logic                    owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        id_q;
    logic        we_q;
    logic        owner_q;
    logic [31:0] praddr_q;
    logic [31:0] prwd_q;
    logic        prwe_q;
    logic        ack0_q, ack1_q;
    logic        err0_q, err1_q;
    logic [31:0] rd0_q, rd1_q;

    logic        any_req_d;
    logic        sel_d;
    logic [31:0] addr_d;
    logic [31:0] wd_d;
    logic        we_d;
    logic        legal_d;

    // owner_q doubles as last-grant: on contention the other master wins.
    always_comb begin
        any_req_d = m0.req | m1.req;
        sel_d     = (m0.req & m1.req) ? ~owner_q : m1.req;
        addr_d    = sel_d ? m1.addr : m0.addr;
        wd_d      = sel_d ? m1.wd   : m0.wd;
        we_d      = sel_d ? m1.we   : m0.we;
        legal_d   = (addr_d[1:0] == 2'b00)
                 && (addr_d >= DEV_BASE) && (addr_d <= DEV_LAST)
                 && !((addr_d >= HOLE_LO) && (addr_d <= HOLE_HI));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            owner_q  <= 1'b1;
            praddr_q <= 32'd0;
            prwd_q   <= 32'd0;
            prwe_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rd0_q    <= 32'd0;
            rd1_q    <= 32'd0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q <= sel_d;
                        id_q    <= sel_d;
                        we_q    <= we_d;
                        if (legal_d) begin
                            state_q  <= S_ACCESS;
                            cnt_q    <= WAIT_INIT;
                            praddr_q <= addr_d;
                            prwd_q   <= wd_d;
                            prwe_q   <= we_d;
                        end else begin
                            // Decode error: bridge stays untouched, answer next cycle.
                            state_q <= S_DONE;
                            if (sel_d) begin
                                ack1_q <= 1'b1;
                                err1_q <= 1'b1;
                                rd1_q  <= 32'd0;
                            end else begin
                                ack0_q <= 1'b1;
                                err0_q <= 1'b1;
                                rd0_q  <= 32'd0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    prwe_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_DONE;
                        praddr_q <= 32'd0;
                        prwd_q   <= 32'd0;
                        if (id_q) begin
                            ack1_q <= 1'b1;
                            if (!we_q) rd1_q <= PrRD;
                        end else begin
                            ack0_q <= 1'b1;
                            if (!we_q) rd0_q <= PrRD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PrAddr = praddr_q;
    assign PrWD   = prwd_q;
    assign PrWE   = prwe_q;
    assign busy   = (state_q != S_IDLE);
    assign owner  = owner_q;

    assign m0.ack = ack0_q;
    assign m0.err = err0_q;
    assign m0.rd  = rd0_q;
    assign m1.ack = ack1_q;
    assign m1.err = err1_q;
    assign m1.rd  = rd1_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench: three arbiters (WAIT_CYCLES 0, 3, 5) on one clock, checked with immediate assertions.
module tb_bridge_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bridge_arbiter_if m0a();
    bridge_arbiter_if m1a();
    bridge_arbiter_if m0b();
    bridge_arbiter_if m1b();
    bridge_arbiter_if m0c();
    bridge_arbiter_if m1c();

    logic [31:0] praddr0, prwd0, prrd0;
    logic        prwe0, busy0, owner0;
    logic [31:0] praddr3, prwd3, prrd3;
    logic        prwe3, busy3, owner3;
    logic [31:0] praddr5, prwd5, prrd5;
    logic        prwe5, busy5, owner5;

    bridge_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .m0(m0a.slave), .m1(m1a.slave),
        .PrAddr(praddr0), .PrWD(prwd0), .PrWE(prwe0), .PrRD(prrd0),
        .busy(busy0), .owner(owner0)
    );

    bridge_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .m0(m0b.slave), .m1(m1b.slave),
        .PrAddr(praddr3), .PrWD(prwd3), .PrWE(prwe3), .PrRD(prrd3),
        .busy(busy3), .owner(owner3)
    );

    bridge_arbiter #(.WAIT_CYCLES(5)) u_dut5 (
        .clk(clk), .reset(reset), .m0(m0c.slave), .m1(m1c.slave),
        .PrAddr(praddr5), .PrWD(prwd5), .PrWE(prwe5), .PrRD(prrd5),
        .busy(busy5), .owner(owner5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] dec_addr [8];
    logic        dec_err  [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        m0a.req = 0; m0a.addr = 0; m0a.wd = 0; m0a.we = 0;
        m1a.req = 0; m1a.addr = 0; m1a.wd = 0; m1a.we = 0;
        m0b.req = 0; m0b.addr = 0; m0b.wd = 0; m0b.we = 0;
        m1b.req = 0; m1b.addr = 0; m1b.wd = 0; m1b.we = 0;
        m0c.req = 0; m0c.addr = 0; m0c.wd = 0; m0c.we = 0;
        m1c.req = 0; m1c.addr = 0; m1c.wd = 0; m1c.we = 0;
        prrd0 = 32'hDEADBEEF;
        prrd3 = 32'hFFFFFFFF;
        prrd5 = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",   busy0,   0);
        chk("rst_owner",  owner0,  1);
        chk("rst_praddr", praddr0, 0);
        chk("rst_prwd",   prwd0,   0);
        chk("rst_prwe",   prwe0,   0);
        chk("rst_ack0",   m0a.ack, 0);
        chk("rst_ack1",   m1a.ack, 0);
        chk("rst_rd0",    m0a.rd,  0);
        chk("rst_rd1",    m1a.rd,  0);
        reset = 1'b0;
        tick();

        // m0 read, WAIT_CYCLES=0
        m0a.req = 1; m0a.addr = 32'h7f04; m0a.we = 0;
        tick();
        chk("rd_praddr", praddr0, 32'h7f04);
        chk("rd_prwe_a", prwe0,   0);
        chk("rd_ack_a",  m0a.ack, 0);
        chk("rd_busy",   busy0,   1);
        chk("rd_owner",  owner0,  0);
        tick();
        chk("rd_ack",    m0a.ack, 1);
        chk("rd_err",    m0a.err, 0);
        chk("rd_data",   m0a.rd,  32'hDEADBEEF);
        chk("rd_prwe_d", prwe0,   0);
        chk("rd_addr_d", praddr0, 0);
        m0a.req = 0;
        tick();
        chk("rd_ack_off", m0a.ack, 0);
        chk("rd_idle",    busy0,   0);
        chk("rd_hold",    m0a.rd,  32'hDEADBEEF);

        // Continuous dual requests from reset: strict alternation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        prrd0 = 32'hCAFE0000;
        m0a.req = 1; m0a.addr = 32'h7f10; m0a.we = 0;
        m1a.req = 1; m1a.addr = 32'h7f20; m1a.we = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("rr_ack0_%0d", k),  m0a.ack, (k % 6 == 2) ? 1 : 0);
            chk($sformatf("rr_ack1_%0d", k),  m1a.ack, (k % 6 == 5) ? 1 : 0);
            chk($sformatf("rr_owner_%0d", k), owner0,  ((k - 1) / 3) % 2);
            chk($sformatf("rr_both_%0d", k),  m0a.ack & m1a.ack, 0);
        end
        m0a.req = 0;
        m1a.req = 0;
        tick();
        chk("rr_idle",  busy0,  0);
        chk("rr_last",  owner0, 1);
        chk("rr_rd0",   m0a.rd, 32'hCAFE0000);

        // Address decode, including window edges and the hole
        prrd0 = 32'h0C0C0000;
        dec_addr[0] = 32'h7f0c;      dec_err[0] = 1;
        dec_addr[1] = 32'h7f44;      dec_err[1] = 1;
        dec_addr[2] = 32'h7f02;      dec_err[2] = 1;
        dec_addr[3] = 32'h7f00;      dec_err[3] = 0;
        dec_addr[4] = 32'h7f40;      dec_err[4] = 0;
        dec_addr[5] = 32'h7f10;      dec_err[5] = 0;
        dec_addr[6] = 32'h7efc;      dec_err[6] = 1;
        dec_addr[7] = 32'h8000_7f00; dec_err[7] = 1;
        for (int i = 0; i < 8; i++) begin
            m0a.req = 1; m0a.addr = dec_addr[i]; m0a.we = 0;
            tick();
            if (dec_err[i]) begin
                chk($sformatf("dec%0d_ack", i),  m0a.ack, 1);
                chk($sformatf("dec%0d_err", i),  m0a.err, 1);
                chk($sformatf("dec%0d_rd", i),   m0a.rd,  0);
                chk($sformatf("dec%0d_addr", i), praddr0, 0);
                chk($sformatf("dec%0d_we", i),   prwe0,   0);
            end else begin
                chk($sformatf("dec%0d_ack", i),  m0a.ack, 0);
                chk($sformatf("dec%0d_addr", i), praddr0, dec_addr[i]);
                tick();
                chk($sformatf("dec%0d_ack2", i), m0a.ack, 1);
                chk($sformatf("dec%0d_err", i),  m0a.err, 0);
                chk($sformatf("dec%0d_rd", i),   m0a.rd,  32'h0C0C0000);
            end
            m0a.req = 0;
            tick();
            chk($sformatf("dec%0d_idle", i), busy0, 0);
        end

        // m1 read arrives while m0 is in ACCESS; served right after m0's DONE
        prrd0 = 32'h0A0A0A0A;
        m0a.req = 1; m0a.addr = 32'h7f04; m0a.we = 0;
        tick();
        m1a.req = 1; m1a.addr = 32'h7f20; m1a.we = 0;
        chk("pend_m0_addr", praddr0, 32'h7f04);
        tick();
        chk("pend_m0_ack", m0a.ack, 1);
        chk("pend_m0_rd",  m0a.rd,  32'h0A0A0A0A);
        chk("pend_m1_ack", m1a.ack, 0);
        m0a.req = 0;
        prrd0 = 32'h0B0B0B0B;
        tick();
        chk("pend_idle",  busy0,  0);
        tick();
        chk("pend_owner", owner0,  1);
        chk("pend_addr",  praddr0, 32'h7f20);
        tick();
        chk("pend_m1_ack2", m1a.ack, 1);
        chk("pend_m1_rd",   m1a.rd,  32'h0B0B0B0B);
        chk("pend_m0_keep", m0a.rd,  32'h0A0A0A0A);
        chk("pend_m0_noack", m0a.ack, 0);
        m1a.req = 0;
        tick();

        // m1 write, WAIT_CYCLES=3
        m1b.req = 1; m1b.addr = 32'h7f40; m1b.wd = 32'h12345678; m1b.we = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("wr_ack_%0d", k), m1b.ack, (k == 5) ? 1 : 0);
            chk($sformatf("wr_we_%0d", k),  prwe3,   (k == 1) ? 1 : 0);
            chk($sformatf("wr_addr_%0d", k), praddr3, (k <= 4) ? 32'h7f40 : 32'h0);
            chk($sformatf("wr_wd_%0d", k),  prwd3,   (k <= 4) ? 32'h12345678 : 32'h0);
        end
        chk("wr_err", m1b.err, 0);
        chk("wr_rd",  m1b.rd,  0);
        m1b.req = 0;
        tick();

        // Reset in the middle of a WAIT_CYCLES=5 write
        m0c.req = 1; m0c.addr = 32'h7f08; m0c.wd = 32'h55AA; m0c.we = 1;
        tick();
        chk("mr_we1",  prwe5, 1);
        tick();
        chk("mr_busy", busy5, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_rst_we",   prwe5,   0);
        chk("mr_rst_busy", busy5,   0);
        chk("mr_rst_addr", praddr5, 0);
        chk("mr_rst_ack",  m0c.ack, 0);
        tick();
        chk("mr_rst_ack2", m0c.ack, 0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("mr_ack_%0d", k), m0c.ack, (k == 7) ? 1 : 0);
            chk($sformatf("mr_we_%0d", k),  prwe5,   (k == 1) ? 1 : 0);
        end
        chk("mr_err", m0c.err, 0);
        m0c.req = 0;
        tick();
        chk("mr_idle", busy5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Two-master arbiter and sequencer in front of the system bridge's single processor-side port (PrAddr/PrWD/PrWE/PrRD).
- Master 0 is the CPU data port; master 1 is the DMA/debug master.
- Grants the bridge round-robin, drives one single-beat transaction at a time with a fixed wait-state window, and returns read data plus a one-cycle acknowledge.
- Rejects accesses outside the device window without touching the bridge.

Parameters:
WAIT_CYCLES, 0, extra bridge access cycles beyond the first (0..15)
DEV_BASE, 32'h0000_7f00, lowest legal device address
DEV_LAST, 32'h0000_7f43, highest legal device address
HOLE_LO, 32'h0000_7f0c, first address of unmapped hole
HOLE_HI, 32'h0000_7f0f, last address of unmapped hole

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
m0_req  in  1  master 0 request; held with m0_addr/m0_wd/m0_we stable until m0_ack
m0_addr  in  32  master 0 byte address
m0_wd  in  32  master 0 write data
m0_we  in  1  master 0 write (1) / read (0)
m0_ack  out  1  one-cycle completion pulse to master 0
m0_err  out  1  valid with m0_ack; 1 = decode error
m0_rd  out  32  master 0 read data, valid with m0_ack, held until next m0 completion
m1_req, m1_addr, m1_wd, m1_we, m1_ack, m1_err, m1_rd  same as master 0, for master 1
PrAddr  out  32  address to bridge
PrWD  out  32  write data to bridge
PrWE  out  1  write enable to bridge
PrRD  in  32  read data from bridge (combinational from PrAddr)
busy  out  1  1 when state != IDLE
owner  out  1  master currently or last granted

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high on reset. Reset forces state=IDLE, all acks/errs=0, m0_rd=m1_rd=0, PrAddr=PrWD=0, PrWE=0, busy=0, and owner/last-grant=1, so master 0 wins the first contention.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Sample requests.
  - Exactly one req high: grant that master.
  - Both high: grant the master not equal to last-grant.
  - On grant, latch addr/wd/we/id into holding registers and update owner.
  - Legal address (word-aligned, DEV_BASE..DEV_LAST, not within HOLE_LO..HOLE_HI): go to ACCESS with wait counter = WAIT_CYCLES.
  - Illegal address: go to DONE with err flag set; the bridge is never driven.
- ACCESS:
  - PrAddr/PrWD come from the holding registers.
  - PrWE=latched we only in the first ACCESS cycle, so each write strobe is exactly one cycle.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture PrRD into the granted master's rd register (reads only; writes leave rd unchanged), then go to DONE.
- DONE:
  - Granted master's ack=1 for exactly one cycle; err per flag (error responses set rd=0).
  - PrWE=0, PrAddr/PrWD=0.
  - Next state IDLE.
- Outside ACCESS: PrAddr=PrWD=0 and PrWE=0.
- Latency, request in IDLE cycle t to ack:
  - Legal access: cycle t+WAIT_CYCLES+2.
  - Illegal access: cycle t+1.
- Masters deassert req the cycle after ack, or keep it high to start a new transaction; req is only sampled in IDLE.
- Requests arriving during ACCESS/DONE wait; there is no preemption.
- Fairness: under continuous dual requests, grants strictly alternate.
- Reset mid-transaction: the transaction is abandoned with no ack and PrWE drops immediately. The master must re-issue.
- Address compare is unsigned 32-bit. Misalignment (addr[1:0]!=0) is a decode error.

Test Plan:
- Reset, then m0 read of 0x7f04 with PrRD=0xDEADBEEF, WAIT_CYCLES=0 -> PrAddr=0x7f04 for one cycle, m0_ack at t+2, m0_rd=0xDEADBEEF, m0_err=0, PrWE never 1.
- m1 write 0x7f40 data 0x12345678, WAIT_CYCLES=3 -> PrWE high exactly one cycle with PrWD=0x12345678, PrAddr held 4 cycles, m1_ack at t+5.
- m0 and m1 both requesting continuously from reset -> grant order m0,m1,m0,m1; owner toggles; no ack ever asserted to both masters in the same cycle.
- m0 access to 0x7f0c, 0x7f44 and 0x7f02 -> each returns m0_ack at t+1 with m0_err=1, m0_rd=0; PrWE and PrAddr stay 0.
- Assert reset during ACCESS of a WAIT_CYCLES=5 write -> PrWE=0 and busy=0 immediately, no ack; a subsequent re-issued request completes normally.
- m1 read held pending while an m0 transaction is in ACCESS -> m1 is granted in the IDLE cycle after m0's DONE; m0_rd is unchanged by m1's read.
